// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg: shared RV32 pipeline encodings (opcodes, ALU ops, M-extension ops)
// Revision: 1.0
// ============================================================================
package riscv_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } muldiv_state_e;

   function automatic logic is_div_op(input muldiv_op_e op);
      return op[2];
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// muldiv_core: unsigned shift-add multiply / restoring divide datapath
// Revision: 1.0
// ============================================================================
module muldiv_core #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_i,
   input  logic              step_i,
   input  logic              is_div_i,
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   output logic [2*XLEN-1:0] product_o,
   output logic [XLEN-1:0]   quotient_o,
   output logic [XLEN-1:0]   remainder_o
);

   // Upper half: partial product / partial remainder. Lower half: multiplier / quotient.
   logic [2*XLEN-1:0] r_acc;
   logic [2*XLEN-1:0] w_acc_mul;
   logic [2*XLEN-1:0] w_acc_div;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_shift;
   logic [XLEN-1:0]   w_diff;
   logic              w_fits;

   assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, b_i} : '0);
   assign w_acc_mul = {w_sum, r_acc[XLEN-1:1]};

   // The true difference is always below the divisor, so 32 bits hold it exactly.
   assign w_shift   = r_acc[2*XLEN-1:XLEN-1];
   assign w_fits    = (w_shift >= {1'b0, b_i});
   assign w_diff    = w_shift[XLEN-1:0] - b_i;
   assign w_acc_div = w_fits ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                             : {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (init_i) begin
         r_acc <= {{XLEN{1'b0}}, a_i};
      end else if (step_i) begin
         r_acc <= is_div_i ? w_acc_div : w_acc_mul;
      end
   end

   assign product_o   = r_acc;
   assign quotient_o  = r_acc[XLEN-1:0];
   assign remainder_o = r_acc[2*XLEN-1:XLEN];

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer: RV32M iterative mul/div control with pipeline stall/flush
// Revision: 1.0
// ============================================================================
module muldiv_sequencer
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e     r_state, w_next;
   muldiv_op_e        w_op, r_op;
   logic [5:0]        r_cnt;
   logic              r_a_neg, r_b_neg, r_special;
   logic [XLEN-1:0]   r_b_mag, r_spec_res;
   logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
   logic              w_div0, w_ovf, w_accept, w_step;
   logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec_res;
   logic [2*XLEN-1:0] w_prod_raw, w_prod;
   logic [XLEN-1:0]   w_quot_raw, w_rem_raw, w_quot, w_rem;

   assign w_op    = muldiv_op_e'(funct3_i);
   assign w_a_sgn = (w_op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
   assign w_b_sgn = (w_op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
   assign w_a_neg = w_a_sgn & a_i[XLEN-1];
   assign w_b_neg = w_b_sgn & b_i[XLEN-1];
   assign w_a_mag = w_a_neg ? (~a_i + 1'b1) : a_i;
   assign w_b_mag = w_b_neg ? (~b_i + 1'b1) : b_i;

   // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
   assign w_div0     = is_div_op(w_op) & (b_i == '0);
   assign w_ovf      = ((w_op == MD_DIV) | (w_op == MD_REM)) & (a_i == MIN_INT) & (b_i == '1);
   assign w_spec_res = w_div0 ? (funct3_i[1] ? a_i : '1)
                              : (funct3_i[1] ? '0  : MIN_INT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= MD_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_step   = 1'b0;
      stall_o  = 1'b0;
      done_o   = 1'b0;
      case (r_state)
         MD_IDLE: begin
            if (start_i && !flush_i) begin
               w_accept = 1'b1;
               stall_o  = 1'b1;
               w_next   = (w_div0 || w_ovf) ? MD_DONE : MD_BUSY;
            end
         end
         MD_BUSY: begin
            stall_o = 1'b1;
            w_step  = 1'b1;
            if (r_cnt == 6'd31) w_next = MD_DONE;
         end
         MD_DONE: begin
            done_o = 1'b1;
            w_next = MD_IDLE;
         end
         default: w_next = MD_IDLE;
      endcase
      if (flush_i) w_next = MD_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op       <= MD_MUL;
         r_a_neg    <= 1'b0;
         r_b_neg    <= 1'b0;
         r_b_mag    <= '0;
         r_special  <= 1'b0;
         r_spec_res <= '0;
         r_cnt      <= '0;
      end else if (w_accept) begin
         r_op       <= w_op;
         r_a_neg    <= w_a_neg;
         r_b_neg    <= w_b_neg;
         r_b_mag    <= w_b_mag;
         r_special  <= w_div0 | w_ovf;
         r_spec_res <= w_spec_res;
         r_cnt      <= '0;
      end else if (w_step) begin
         r_cnt      <= r_cnt + 6'd1;
      end
   end

   muldiv_core #(.XLEN(XLEN)) u_core (
      .clk         (clk),
      .rst         (rst),
      .init_i      (w_accept),
      .step_i      (w_step),
      .is_div_i    (is_div_op(r_op)),
      .a_i         (w_a_mag),
      .b_i         (r_b_mag),
      .product_o   (w_prod_raw),
      .quotient_o  (w_quot_raw),
      .remainder_o (w_rem_raw)
   );

   // Unsigned ops never set the sign flags, so the fix-up is a no-op for them.
   assign w_prod = (r_a_neg ^ r_b_neg) ? (~w_prod_raw + 1'b1) : w_prod_raw;
   assign w_quot = (r_a_neg ^ r_b_neg) ? (~w_quot_raw + 1'b1) : w_quot_raw;
   assign w_rem  = r_a_neg ? (~w_rem_raw + 1'b1) : w_rem_raw;

   always_comb begin
      result_o = '0;
      if (r_state == MD_DONE) begin
         if (r_special) begin
            result_o = r_spec_res;
         end else begin
            case (r_op)
               MD_MUL:                       result_o = w_prod[XLEN-1:0];
               MD_MULH, MD_MULHSU, MD_MULHU: result_o = w_prod[2*XLEN-1:XLEN];
               MD_DIV, MD_DIVU:              result_o = w_quot;
               default:                      result_o = w_rem;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer: vector table, corner sequences and random ops vs model
// Revision: 1.0
// ============================================================================
module tb_muldiv_sequencer;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [2:0]  funct3_i = 3'b000;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        stall_o, done_o;
   logic [31:0] result_o;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .funct3_i (funct3_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .flush_i  (flush_i),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
   endtask

   // Reference model: plain 64-bit arithmetic plus the RV32M special-case rules.
   function automatic void ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output int lat);
      longint      sa, sb;
      logic [63:0] p;
      int          qa, qb;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      qa  = $signed(a);
      qb  = $signed(b);
      lat = 33;
      res = '0;
      case (f)
         3'b000: begin p = sa * sb; res = p[31:0]; end
         3'b001: begin p = sa * sb; res = p[63:32]; end
         3'b010: begin p = sa * longint'({32'h0, b}); res = p[63:32]; end
         3'b011: begin p = {32'h0, a} * {32'h0, b}; res = p[63:32]; end
         3'b100: begin
            if (b == 0) begin res = 32'hFFFFFFFF; lat = 1; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin res = 32'h80000000; lat = 1; end
            else res = qa / qb;
         end
         3'b101: begin
            if (b == 0) begin res = 32'hFFFFFFFF; lat = 1; end
            else res = a / b;
         end
         3'b110: begin
            if (b == 0) begin res = a; lat = 1; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin res = 32'h0; lat = 1; end
            else res = qa % qb;
         end
         default: begin
            if (b == 0) begin res = a; lat = 1; end
            else res = a % b;
         end
      endcase
   endfunction

   // Issue one op in the current cycle (cycle 0) and follow it to its done pulse.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input bit hold, input string name);
      int          lat;
      bit          bad;
      logic [31:0] got;
      funct3_i = f; a_i = a; b_i = b; start_i = 1'b1;
      @(negedge clk);
      bad = (stall_o !== 1'b1) || (done_o !== 1'b0);
      @(posedge clk); #1;
      if (!hold) begin
         start_i  = 1'b0;
         funct3_i = 3'($urandom);
         a_i      = $urandom;
         b_i      = $urandom;
      end
      lat = 0;
      got = '0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(negedge clk);
         if (done_o === 1'b1) begin
            lat = c;
            got = result_o;
            if (stall_o !== 1'b0) bad = 1'b1;
         end else begin
            if (stall_o !== 1'b1 || result_o !== 32'h0) bad = 1'b1;
            @(posedge clk); #1;
         end
      end
      check({name, "_result"}, got, exp);
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_stall_profile"}, 32'(bad), 32'd0);
      @(posedge clk); #1;
      if (hold) begin
         start_i = 1'b0;
         #1;
         check({name, "_start_in_done_ignored"}, 32'(stall_o), 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] er, ra, rb;
      logic [2:0]  rf;
      int          el, dones;

      vt[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      vt[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      vt[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
      vt[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
      vt[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
      vt[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
      vt[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
      vt[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
      vt[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vt[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
      vt[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vt[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
      vt[12] = '{3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 33};
      vt[13] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
      vt[14] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33};
      vt[15] = '{3'b100, 32'h80000000, 32'd1,        32'h80000000, 33};
      vt[16] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
      vt[17] = '{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1};

      // Reset state
      #12;
      check("reset_stall",  32'(stall_o), 32'd0);
      check("reset_done",   32'(done_o),  32'd0);
      check("reset_result", result_o,     32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vt[i])
         run_op(vt[i].f, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, 1'b0, $sformatf("vec%0d", i));

      // Start held high through DONE must not launch a second op.
      run_op(3'b101, 32'd50, 32'd5, 32'd10, 33, 1'b1, "hold_start");

      // Flush in cycle 10 of a MUL, then DIVU 9/3 issued in cycle 11.
      funct3_i = 3'b000; a_i = 32'd1234; b_i = 32'd5678; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      dones = 0;
      for (int c = 1; c < 10; c++) begin
         @(negedge clk);
         if (done_o === 1'b1) dones++;
         @(posedge clk); #1;
      end
      flush_i = 1'b1;
      @(negedge clk);
      if (done_o === 1'b1) dones++;
      check("flush_busy_stall", 32'(stall_o), 32'd1);
      @(posedge clk); #1;
      flush_i = 1'b0;
      #1;
      check("flush_next_stall", 32'(stall_o), 32'd0);
      check("flush_no_done", 32'(dones + int'(done_o)), 32'd0);
      run_op(3'b101, 32'd9, 32'd3, 32'd3, 33, 1'b0, "flush_then_divu");

      // Start coinciding with flush is dropped.
      funct3_i = 3'b000; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1; flush_i = 1'b1;
      #1;
      check("start_flush_stall", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      check("start_flush_dropped_stall", 32'(stall_o), 32'd0);
      check("start_flush_dropped_done",  32'(done_o),  32'd0);
      @(posedge clk); #1;

      // Asynchronous reset mid-cycle 15 of a DIV.
      funct3_i = 3'b100; a_i = 32'hFFFFFF9C; b_i = 32'd7; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check("busy_before_reset", 32'(stall_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_stall",  32'(stall_o), 32'd0);
      check("async_reset_done",   32'(done_o),  32'd0);
      check("async_reset_result", result_o,     32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33, 1'b0, "div_after_reset");

      // Asynchronous reset during the DONE cycle clears the result at once.
      funct3_i = 3'b000; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      dones = 0;
      for (int c = 1; c <= 40 && dones == 0; c++) begin
         @(negedge clk);
         if (done_o === 1'b1) dones = 1;
      end
      check("done_before_reset", result_o, 32'd15);
      #1 rst = 1'b1;
      #1;
      check("reset_in_done_result", result_o,    32'd0);
      check("reset_in_done_done",   32'(done_o), 32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Randomised ops against the reference model.
      for (int i = 0; i < 150; i++) begin
         rf = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       ra = 32'h0;
            1:       ra = 32'h80000000;
            2:       ra = 32'hFFFFFFFF;
            3:       ra = $urandom_range(0, 15);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       rb = 32'h0;
            1:       rb = 32'h80000000;
            2:       rb = 32'hFFFFFFFF;
            3:       rb = $urandom_range(0, 15);
            default: rb = $urandom;
         endcase
         ref_model(rf, ra, rb, er, el);
         run_op(rf, ra, rb, er, el, 1'b0, $sformatf("rand%0d_f%0d", i, rf));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
